// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and the data stage.
// Define FAIR_ARB_EN for round-robin on collisions; otherwise the data stage always wins.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              mem_rd_req,
   input  logic              mem_wr_req,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_read,
   output logic              m_write,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] if_addr_q, if_addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;
   logic              if_elig, mem_elig;
   logic              grant_if, grant_mem;

   // A requester whose done pulse is high this cycle is still holding its old request.
   assign if_elig  = if_req & ~if_done_q;
   assign mem_elig = (mem_rd_req | mem_wr_req) & ~mem_done_q;

`ifdef FAIR_ARB_EN
   logic last_mem_q, last_mem_d;

   assign grant_mem = mem_elig & (~if_elig | ~last_mem_q);
`else
   assign grant_mem = mem_elig;
`endif
   assign grant_if  = if_elig & ~grant_mem;

   always_comb begin
      state_d     = state_q;
      if_addr_d   = if_addr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
`ifdef FAIR_ARB_EN
      last_mem_d  = last_mem_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_mem) begin
               state_d     = MEM_BUSY;
               mem_addr_d  = mem_addr;
               mem_wdata_d = mem_wdata;
               mem_wr_d    = mem_wr_req;
               mem_rd_d    = mem_rd_req & ~mem_wr_req;
`ifdef FAIR_ARB_EN
               last_mem_d  = 1'b1;
`endif
            end else if (grant_if) begin
               state_d   = IF_BUSY;
               if_addr_d = if_addr;
`ifdef FAIR_ARB_EN
               last_mem_d = 1'b0;
`endif
            end
         end
         IF_BUSY: begin
            if (m_ready) begin
               state_d    = IDLE;
               if_done_d  = 1'b1;
               if_rdata_d = m_rdata;
            end
         end
         MEM_BUSY: begin
            if (m_ready) begin
               state_d    = IDLE;
               mem_done_d = 1'b1;
               if (mem_rd_q) begin
                  mem_rdata_d = m_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory strobes come only from the state register and latched fields.
   always_comb begin
      m_read  = 1'b0;
      m_write = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      case (state_q)
         IF_BUSY: begin
            m_read = 1'b1;
            m_addr = if_addr_q;
         end
         MEM_BUSY: begin
            m_read  = mem_rd_q;
            m_write = mem_wr_q;
            m_addr  = mem_addr_q;
            m_wdata = mem_wdata_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         if_addr_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
`ifdef FAIR_ARB_EN
         last_mem_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         if_addr_q   <= if_addr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
`ifdef FAIR_ARB_EN
         last_mem_q  <= last_mem_d;
`endif
      end
   end

   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_done   = if_done_q;
   assign mem_done  = mem_done_q;
   assign stall_if  = if_req & ~if_done_q;
   assign stall_mem = (mem_rd_req | mem_wr_req) & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef FAIR_ARB_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif
   localparam int OWN_NONE  = 0;
   localparam int OWN_FETCH = 1;
   localparam int OWN_DATA  = 2;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          mem_rd_req;
   logic          mem_wr_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ready;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_read;
   logic          m_write;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;
   logic          stall_if;
   logic          stall_mem;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_read(m_read), .m_write(m_write),
      .if_rdata(if_rdata), .if_done(if_done),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: who owns the port, what access it is, and what has completed.
   int            mOwner;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mWdata;
   bit            mRd, mWr, mIfDone, mMemDone, mLastData, modelValid;
   logic [DW-1:0] mIfRdata, mMemRdata;
   bit            newIfDone, newMemDone, wantIf, wantMem, takeMem;

   initial modelValid = 1'b0;

   always @(posedge clk) begin
      newIfDone  = 1'b0;
      newMemDone = 1'b0;
      if (!rst) begin
         mOwner = OWN_NONE; mAddr = '0; mWdata = '0; mRd = 1'b0; mWr = 1'b0;
         mIfRdata = '0; mMemRdata = '0; mLastData = 1'b0; modelValid = 1'b1;
      end else if (mOwner == OWN_FETCH) begin
         if (m_ready) begin
            mIfRdata = m_rdata; newIfDone = 1'b1; mOwner = OWN_NONE;
         end
      end else if (mOwner == OWN_DATA) begin
         if (m_ready) begin
            if (mRd) mMemRdata = m_rdata;
            newMemDone = 1'b1; mOwner = OWN_NONE;
         end
      end else begin
         wantIf  = if_req && !mIfDone;
         wantMem = (mem_rd_req || mem_wr_req) && !mMemDone;
         if (wantIf && wantMem) takeMem = FAIR ? !mLastData : 1'b1;
         else                   takeMem = wantMem;
         if (takeMem) begin
            mOwner = OWN_DATA; mAddr = mem_addr; mWdata = mem_wdata;
            mWr = mem_wr_req; mRd = !mem_wr_req; mLastData = 1'b1;
         end else if (wantIf) begin
            mOwner = OWN_FETCH; mAddr = if_addr; mWdata = '0;
            mRd = 1'b1; mWr = 1'b0; mLastData = 1'b0;
         end
      end
      mIfDone  = newIfDone;
      mMemDone = newMemDone;
   end

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("model m_read",    m_read,    (mOwner != OWN_NONE) && mRd);
         checkOutput("model m_write",   m_write,   (mOwner == OWN_DATA) && mWr);
         checkOutput("model m_addr",    m_addr,    (mOwner != OWN_NONE) ? mAddr : '0);
         checkOutput("model m_wdata",   m_wdata,   (mOwner != OWN_NONE) ? mWdata : '0);
         checkOutput("model if_done",   if_done,   mIfDone);
         checkOutput("model mem_done",  mem_done,  mMemDone);
         checkOutput("model if_rdata",  if_rdata,  mIfRdata);
         checkOutput("model mem_rdata", mem_rdata, mMemRdata);
         checkOutput("model stall_if",  stall_if,  if_req && !mIfDone);
         checkOutput("model stall_mem", stall_mem, (mem_rd_req || mem_wr_req) && !mMemDone);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit ir, input logic [AW-1:0] ia, input bit mr, input bit mw,
                                input logic [AW-1:0] ma, input logic [DW-1:0] md);
      if_req = ir; if_addr = ia; mem_rd_req = mr; mem_wr_req = mw; mem_addr = ma; mem_wdata = md;
   endtask

   task automatic doReset();
      rst = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      tick(); tick();
      rst = 1'b1;
   endtask

   int  writeCycles;
   bit  fetchFirst;

   initial begin
      rst = 1'b0; m_ready = 1'b0; m_rdata = '0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      doReset();
      checkOutput("reset if_rdata", if_rdata, 32'h0);
      checkOutput("reset mem_rdata", mem_rdata, 32'h0);
      checkOutput("reset m_read", m_read, 1'b0);

      $display("[TB] single fetch");
      m_rdata = 32'h8C220004; m_ready = 1'b1;
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
      #1 checkOutput("fetch stall cycle1", stall_if, 1'b1);
      tick();
      checkOutput("fetch m_read", m_read, 1'b1);
      checkOutput("fetch m_addr", m_addr, 32'h40);
      checkOutput("fetch stall cycle2", stall_if, 1'b1);
      tick();
      checkOutput("fetch if_done", if_done, 1'b1);
      checkOutput("fetch if_rdata", if_rdata, 32'h8C220004);
      checkOutput("fetch stall released", stall_if, 1'b0);
      if_req = 1'b0;
      tick();
      checkOutput("fetch done one pulse", if_done, 1'b0);

      $display("[TB] store with wait states");
      m_rdata = 32'h12345678; m_ready = 1'b0; writeCycles = 0;
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (m_write && m_addr == 32'h100 && m_wdata == 32'hDEADBEEF) writeCycles++;
         checkOutput("store no early done", mem_done, 1'b0);
      end
      m_ready = 1'b1;
      tick();
      checkOutput("store write cycles", writeCycles, 4);
      checkOutput("store mem_done", mem_done, 1'b1);
      checkOutput("store mem_rdata kept", mem_rdata, 32'h0);
      mem_wr_req = 1'b0;
      tick();
      checkOutput("store done one pulse", mem_done, 1'b0);

      $display("[TB] collision after reset");
      doReset();
      m_ready = 1'b1; m_rdata = 32'h0BADF00D;
      applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h200, '0);
      tick();
      checkOutput("collide first addr", m_addr, 32'h200);
      tick();
      checkOutput("collide mem_done", mem_done, 1'b1);
      checkOutput("collide mem_rdata", mem_rdata, 32'h0BADF00D);
      mem_rd_req = 1'b0; m_rdata = 32'h11110000;
      tick();
      checkOutput("collide fetch after gap", m_addr, 32'h44);
      tick();
      checkOutput("collide if_done", if_done, 1'b1);
      checkOutput("collide if_rdata", if_rdata, 32'h11110000);
      if_req = 1'b0;
      tick();

      $display("[TB] repeat collision after a data access");
      m_rdata = 32'h33330000;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h300, '0);
      tick(); tick();
      mem_rd_req = 1'b0;
      tick();
      applyStimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h304, '0);
      fetchFirst = FAIR;
      tick();
      checkOutput("repeat first addr", m_addr, fetchFirst ? 32'h48 : 32'h304);
      tick();
      if (fetchFirst) if_req = 1'b0; else mem_rd_req = 1'b0;
      tick();
      checkOutput("repeat second addr", m_addr, fetchFirst ? 32'h304 : 32'h48);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      tick();

      $display("[TB] read and write together");
      m_rdata = 32'h77777777;
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h500, 32'hCAFEF00D);
      tick();
      checkOutput("rdwr m_write", m_write, 1'b1);
      checkOutput("rdwr m_read", m_read, 1'b0);
      tick();
      checkOutput("rdwr mem_done", mem_done, 1'b1);
      checkOutput("rdwr mem_rdata kept", mem_rdata, 32'h33330000);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      tick();

      $display("[TB] request held through done");
      m_rdata = 32'h66660000;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h600, '0);
      tick();
      checkOutput("hold first grant", m_read, 1'b1);
      tick();
      checkOutput("hold done", mem_done, 1'b1);
      checkOutput("hold idle in done", m_read, 1'b0);
      tick();
      checkOutput("hold no regrant", m_read, 1'b0);
      tick();
      checkOutput("hold regrant", m_read, 1'b1);
      checkOutput("hold regrant addr", m_addr, 32'h600);
      tick();
      mem_rd_req = 1'b0;
      tick();

      $display("[TB] reset during data access");
      m_ready = 1'b0; m_rdata = 32'h99990000;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h700, '0);
      tick();
      checkOutput("abort busy", m_read, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("abort m_read", m_read, 1'b0);
      checkOutput("abort m_write", m_write, 1'b0);
      checkOutput("abort mem_rdata", mem_rdata, 32'h0);
      rst = 1'b1; mem_rd_req = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("abort no mem_done", mem_done, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
